// File: rtl/maze_map_responder.sv
// ---------------------------------------------------------------------------
// maze_map_responder
//
// Memory-side responder for the maze solver's cell-query interface. It holds
// a wall map and a visited map, both loaded byte-serially from a host stream.
// While the solver runs, it answers `oe` reads and records `we` marks. When the
// solver signals `done`, it streams every visited cell back out in row-major
// order.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   load_valid/_data    host byte stream (header row, header col, map bytes)
//   load_ready          host byte accepted when load_valid & load_ready
//   starting_row/_col   start cell taken from header bytes 0 and 1
//   row, col, oe, we    solver cell address, read strobe, mark-visited strobe
//   out                 registered wall bit of the last read cell (1 = wall)
//   solver_start        one-cycle pulse when the map becomes live
//   done                solver finished; starts the visited-cell dump
//   dump_valid/_ready   valid/ready handshake for dumped cells
//   dump_row/_col       coordinates of the presented visited cell
//   finished            dump complete (level)
// ---------------------------------------------------------------------------
module maze_map_responder #(
  parameter int MAZE_DIM = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic [5:0] starting_row,
  output logic [5:0] starting_col,
  input  logic [5:0] row,
  input  logic [5:0] col,
  input  logic       oe,
  input  logic       we,
  output logic       out,
  output logic       solver_start,
  input  logic       done,
  output logic       dump_valid,
  input  logic       dump_ready,
  output logic [5:0] dump_row,
  output logic [5:0] dump_col,
  output logic       finished
);

  localparam int MAP_BYTES = (MAZE_DIM * MAZE_DIM) / 8;
  localparam int ADDR_W    = (MAP_BYTES > 1) ? $clog2(MAP_BYTES) : 1;

  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MAP_BYTES - 1);
  localparam logic [5:0]        LAST_RC   = 6'(MAZE_DIM - 1);
  localparam logic [6:0]        DIM_7     = 7'(MAZE_DIM);

  localparam logic [2:0] HDR0  = 3'd0;
  localparam logic [2:0] HDR1  = 3'd1;
  localparam logic [2:0] MAP   = 3'd2;
  localparam logic [2:0] SERVE = 3'd3;
  localparam logic [2:0] DUMP  = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  // Each map byte holds 8 horizontally adjacent cells. MAZE_DIM is a multiple
  // of 8, so a row starts on a byte boundary and col[2:0] selects the bit.
  function automatic logic [ADDR_W-1:0] cell_byte(input logic [5:0] r,
                                                  input logic [2:0] c_hi);
    return ADDR_W'(r) * ADDR_W'(MAZE_DIM / 8) + ADDR_W'(c_hi);
  endfunction

  // Map storage is never reset; every load rewrites all of it.
  logic [7:0] wall_mem [MAP_BYTES];
  logic [7:0] vis_mem  [MAP_BYTES];

  logic [2:0]        state_r;
  logic              load_ready_r;
  logic [5:0]        start_row_r;
  logic [5:0]        start_col_r;
  logic [ADDR_W-1:0] load_cnt_r;
  logic              out_r;
  logic              solver_start_r;
  logic              dump_valid_r;
  logic [5:0]        dump_row_r;
  logic [5:0]        dump_col_r;
  logic              finished_r;
  logic [5:0]        scan_row_r;
  logic [5:0]        scan_col_r;
  logic              scan_end_r;   // every cell scanned; only a beat may remain

  logic              load_fire_s;
  logic              in_range_s;
  logic [ADDR_W-1:0] rc_byte_s;
  logic [ADDR_W-1:0] scan_byte_s;
  logic              rd_bit_s;
  logic              scan_hit_s;
  logic              scan_last_s;
  logic              map_wr_s;
  logic              mark_s;
  logic              serve_rd_s;

  // Handshake, address decode and map lookups for load, serve and scan.
  always_comb begin
    load_fire_s = load_valid & load_ready_r;
    in_range_s  = ({1'b0, row} < DIM_7) && ({1'b0, col} < DIM_7);
    rc_byte_s   = cell_byte(row, col[5:3]);
    scan_byte_s = cell_byte(scan_row_r, scan_col_r[5:3]);
    if (in_range_s) begin
      rd_bit_s = wall_mem[rc_byte_s][col[2:0]];
    end else begin
      rd_bit_s = 1'b1;   // everything outside the maze reads as wall
    end
    scan_hit_s  = vis_mem[scan_byte_s][scan_col_r[2:0]];
    scan_last_s = (scan_row_r == LAST_RC) && (scan_col_r == LAST_RC);
    map_wr_s    = (state_r == MAP) && load_fire_s;
    mark_s      = (state_r == SERVE) && we && in_range_s;
    serve_rd_s  = (state_r == SERVE) && oe;
  end

  // Map writes: a load byte rewrites 8 wall bits and clears 8 visited bits;
  // a solver mark sets one visited bit.
  always_ff @(posedge clk) begin
    if (map_wr_s) begin
      wall_mem[load_cnt_r] <= load_data;
      vis_mem[load_cnt_r]  <= 8'h00;
    end else if (mark_s) begin
      vis_mem[rc_byte_s][col[2:0]] <= 1'b1;
    end
  end

  // Registered read port; holds its value while no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= 1'b0;
    end else if (serve_rd_s) begin
      out_r <= rd_bit_s;
    end
  end

  // Main control: header/map load, serve, visited-cell dump, finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= HDR0;
      load_ready_r   <= 1'b1;
      start_row_r    <= 6'd0;
      start_col_r    <= 6'd0;
      load_cnt_r     <= '0;
      solver_start_r <= 1'b0;
      dump_valid_r   <= 1'b0;
      dump_row_r     <= 6'd0;
      dump_col_r     <= 6'd0;
      finished_r     <= 1'b0;
      scan_row_r     <= 6'd0;
      scan_col_r     <= 6'd0;
      scan_end_r     <= 1'b0;
    end else begin
      solver_start_r <= 1'b0;
      case (state_r)
        HDR0: begin
          if (load_fire_s) begin
            start_row_r <= load_data[5:0];
            state_r     <= HDR1;
          end
        end
        HDR1: begin
          if (load_fire_s) begin
            start_col_r <= load_data[5:0];
            load_cnt_r  <= '0;
            state_r     <= MAP;
          end
        end
        MAP: begin
          if (load_fire_s) begin
            if (load_cnt_r == LAST_BYTE) begin
              state_r        <= SERVE;
              load_ready_r   <= 1'b0;
              solver_start_r <= 1'b1;
            end else begin
              load_cnt_r <= load_cnt_r + 1'b1;
            end
          end
        end
        SERVE: begin
          if (done) begin
            state_r      <= DUMP;
            scan_row_r   <= 6'd0;
            scan_col_r   <= 6'd0;
            scan_end_r   <= 1'b0;
            dump_valid_r <= 1'b0;
          end
        end
        DUMP: begin
          // Advance only when no beat is held back by the sink.
          if (!dump_valid_r || dump_ready) begin
            if (scan_end_r) begin
              dump_valid_r <= 1'b0;
              finished_r   <= 1'b1;
              load_ready_r <= 1'b1;
              state_r      <= FIN;
            end else begin
              dump_valid_r <= scan_hit_s;
              if (scan_hit_s) begin
                dump_row_r <= scan_row_r;
                dump_col_r <= scan_col_r;
              end
              if (scan_last_s) begin
                if (scan_hit_s) begin
                  scan_end_r <= 1'b1;   // wait for the final beat first
                end else begin
                  finished_r   <= 1'b1;
                  load_ready_r <= 1'b1;
                  state_r      <= FIN;
                end
              end else if (scan_col_r == LAST_RC) begin
                scan_col_r <= 6'd0;
                scan_row_r <= scan_row_r + 6'd1;
              end else begin
                scan_col_r <= scan_col_r + 6'd1;
              end
            end
          end
        end
        FIN: begin
          // A new byte here is header byte 0 of the next load.
          if (load_fire_s) begin
            start_row_r <= load_data[5:0];
            finished_r  <= 1'b0;
            state_r     <= HDR1;
          end
        end
        default: begin
          state_r      <= HDR0;
          load_ready_r <= 1'b1;
          dump_valid_r <= 1'b0;
          finished_r   <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready   = load_ready_r;
  assign starting_row = start_row_r;
  assign starting_col = start_col_r;
  assign out          = out_r;
  assign solver_start = solver_start_r;
  assign dump_valid   = dump_valid_r;
  assign dump_row     = dump_row_r;
  assign dump_col     = dump_col_r;
  assign finished     = finished_r;

endmodule

// File: tb/tb_maze_map_responder.sv
// ---------------------------------------------------------------------------
// tb_maze_map_responder
//
// Directed sequence with randomized map contents, read addresses and marks.
// Expected values come from a cell-level model: a byte image of the map,
// a 64x64 visited array and a row-major list of visited cells. A second
// instance built with MAZE_DIM = 16 covers reads outside the maze.
// ---------------------------------------------------------------------------
module tb_maze_map_responder;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [5:0] starting_row;
  logic [5:0] starting_col;
  logic [5:0] row;
  logic [5:0] col;
  logic       oe;
  logic       we;
  logic       out;
  logic       solver_start;
  logic       done;
  logic       dump_valid;
  logic       dump_ready;
  logic [5:0] dump_row;
  logic [5:0] dump_col;
  logic       finished;

  logic       s_load_valid;
  logic [7:0] s_load_data;
  logic       s_load_ready;
  logic [5:0] s_starting_row;
  logic [5:0] s_starting_col;
  logic [5:0] s_row;
  logic [5:0] s_col;
  logic       s_oe;
  logic       s_we;
  logic       s_out;
  logic       s_solver_start;
  logic       s_done;
  logic       s_dump_valid;
  logic       s_dump_ready;
  logic [5:0] s_dump_row;
  logic [5:0] s_dump_col;
  logic       s_finished;

  int vectors;
  int miscompares;

  logic [7:0]  map_b [512];
  logic [7:0]  sb [32];
  bit          vis_m [64][64];
  logic [11:0] exp_q [$];
  logic        last_out;

  maze_map_responder u_dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .starting_row(starting_row), .starting_col(starting_col),
    .row(row), .col(col), .oe(oe), .we(we), .out(out),
    .solver_start(solver_start), .done(done),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_row(dump_row), .dump_col(dump_col), .finished(finished)
  );

  maze_map_responder #(.MAZE_DIM(16)) u_small (
    .clk(clk), .rst(rst),
    .load_valid(s_load_valid), .load_data(s_load_data), .load_ready(s_load_ready),
    .starting_row(s_starting_row), .starting_col(s_starting_col),
    .row(s_row), .col(s_col), .oe(s_oe), .we(s_we), .out(s_out),
    .solver_start(s_solver_start), .done(s_done),
    .dump_valid(s_dump_valid), .dump_ready(s_dump_ready),
    .dump_row(s_dump_row), .dump_col(s_dump_col), .finished(s_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wall bit of cell (r,c) straight from the loaded byte image.
  function automatic logic exp_wall(input int r, input int c, input int dim);
    int lin;
    logic [7:0] b;
    if (r >= dim || c >= dim) return 1'b1;
    lin = r * dim + c;
    if (dim == 16) b = sb[lin / 8];
    else b = map_b[lin / 8];
    return b[lin % 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic load_map(input logic [7:0] h0, input logic [7:0] h1, input int nbytes);
    int starts;
    starts = 0;
    load_valid = 1'b1;
    load_data  = h0;
    step();
    chk("hdr_row", 32'(starting_row), 32'(h0[5:0]));
    chk("fin_cleared", 32'(finished), 32'd0);
    load_data = h1;
    step();
    chk("hdr_col", 32'(starting_col), 32'(h1[5:0]));
    for (int k = 0; k < nbytes; k++) begin
      load_data = map_b[k];
      step();
      if (solver_start === 1'b1) starts++;
    end
    load_valid = 1'b0;
    if (nbytes == 512) begin
      chk("start_after_last", 32'(solver_start), 32'd1);
      chk("ready_low_serve", 32'(load_ready), 32'd0);
      step();
      chk("start_one_cycle", 32'(solver_start), 32'd0);
      chk("start_pulses", 32'(starts), 32'd1);
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 64; c++)
          vis_m[r][c] = 1'b0;
    end
  endtask

  task automatic rd(input int r, input int c);
    row = 6'(r);
    col = 6'(c);
    oe  = 1'b1;
    step();
    oe = 1'b0;
    last_out = exp_wall(r, c, 64);
    chk("read", 32'(out), 32'(last_out));
  endtask

  task automatic mark(input int r, input int c, input bit with_rd);
    row = 6'(r);
    col = 6'(c);
    we  = 1'b1;
    oe  = with_rd;
    step();
    we = 1'b0;
    oe = 1'b0;
    vis_m[r][c] = 1'b1;
    if (with_rd) begin
      last_out = exp_wall(r, c, 64);
      chk("read_with_mark", 32'(out), 32'(last_out));
    end
  endtask

  // Raise done, then drain beats against the row-major visited list.
  task automatic run_dump(input bit rand_ready, output int beats, output int cycles);
    logic       prev_stall;
    logic [5:0] pr;
    logic [5:0] pc;
    bit         tog;
    int         n_exp;
    logic [31:0] want;
    exp_q.delete();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        if (vis_m[r][c]) exp_q.push_back({6'(r), 6'(c)});
    n_exp = exp_q.size();
    done = 1'b1;
    step();
    done = 1'b0;
    we   = 1'b0;
    oe   = 1'b0;
    chk("first_beat_gap", 32'(dump_valid), 32'd0);
    beats = 0;
    cycles = 0;
    prev_stall = 1'b0;
    pr = 6'd0;
    pc = 6'd0;
    tog = 1'b1;
    while (finished !== 1'b1 && cycles < 9000) begin
      if (rand_ready) dump_ready = 1'($urandom_range(0, 1));
      else dump_ready = tog;
      tog = ~tog;
      if (prev_stall) begin
        chk("stall_valid", 32'(dump_valid), 32'd1);
        chk("stall_row", 32'(dump_row), 32'(pr));
        chk("stall_col", 32'(dump_col), 32'(pc));
      end
      if (dump_valid === 1'b1) begin
        if (dump_ready) begin
          if (exp_q.size() > 0) want = 32'(exp_q.pop_front());
          else want = 32'hFFFF_FFFF;
          chk("beat", 32'({dump_row, dump_col}), want);
          beats++;
        end
        prev_stall = ~dump_ready;
        pr = dump_row;
        pc = dump_col;
      end else begin
        prev_stall = 1'b0;
      end
      step();
      cycles++;
    end
    dump_ready = 1'b0;
    chk("finished", 32'(finished), 32'd1);
    chk("beat_count", 32'(beats), 32'(n_exp));
    chk("ready_in_fin", 32'(load_ready), 32'd1);
  endtask

  initial begin
    int beats;
    int cycles;
    int r;
    int c;
    vectors = 0;
    miscompares = 0;
    last_out = 1'b0;
    rst = 1'b1;
    load_valid = 1'b0; load_data = 8'h00;
    row = 6'd0; col = 6'd0; oe = 1'b0; we = 1'b0; done = 1'b0; dump_ready = 1'b0;
    s_load_valid = 1'b0; s_load_data = 8'h00;
    s_row = 6'd0; s_col = 6'd0; s_oe = 1'b0; s_we = 1'b0; s_done = 1'b0; s_dump_ready = 1'b0;
    for (int r0 = 0; r0 < 64; r0++)
      for (int c0 = 0; c0 < 64; c0++)
        vis_m[r0][c0] = 1'b0;
    step();
    step();

    // Reset values while rst is high.
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_start_row", 32'(starting_row), 32'd0);
    chk("rst_start_col", 32'(starting_col), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_solver_start", 32'(solver_start), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    rst = 1'b0;
    step();

    // 16x16 instance: header, 32 map bytes, then in- and out-of-range reads.
    for (int k = 0; k < 32; k++) sb[k] = 8'($urandom);
    sb[0] = 8'h00;
    s_load_valid = 1'b1;
    s_load_data = 8'h07;
    step();
    s_load_data = 8'h09;
    step();
    for (int k = 0; k < 32; k++) begin
      s_load_data = sb[k];
      step();
    end
    s_load_valid = 1'b0;
    chk("small_hdr_row", 32'(s_starting_row), 32'd7);
    chk("small_hdr_col", 32'(s_starting_col), 32'd9);
    chk("small_start", 32'(s_solver_start), 32'd1);
    chk("small_ready_low", 32'(s_load_ready), 32'd0);
    for (int k = 0; k < 12; k++) begin
      case (k)
        0, 2: begin r = 0; c = 0; end
        1: begin r = 20; c = 2; end
        3: begin r = 2; c = 20; end
        4: begin r = 63; c = 63; end
        default: begin r = $urandom_range(0, 15); c = $urandom_range(0, 15); end
      endcase
      s_row = 6'(r);
      s_col = 6'(c);
      s_oe = 1'b1;
      step();
      s_oe = 1'b0;
      chk("small_read", 32'(s_out), 32'(exp_wall(r, c, 16)));
    end
    chk("small_no_dump", 32'({s_dump_valid, s_finished, s_dump_row, s_dump_col}), 32'd0);

    // Header 3,5 and a 0xAA map; reads follow the alternating column pattern.
    for (int k = 0; k < 512; k++) map_b[k] = 8'hAA;
    load_map(8'h03, 8'h05, 512);
    rd(0, 0);
    chk("aa_cell00", 32'(out), 32'd0);
    rd(0, 1);
    chk("aa_cell01", 32'(out), 32'd1);
    row = 6'd0; col = 6'd0;
    step();
    chk("out_holds", 32'(out), 32'd1);
    for (int k = 0; k < 10; k++) rd($urandom_range(0, 63), $urandom_range(0, 63));

    mark(3, 5, 1'b0);
    mark(3, 6, 1'b0);
    mark(4, 6, 1'b0);
    run_dump(1'b0, beats, cycles);

    // Reads are ignored outside SERVE.
    row = 6'd0; col = last_out ? 6'd0 : 6'd1; oe = 1'b1;
    step();
    oe = 1'b0;
    chk("oe_ignored_fin", 32'(out), 32'(last_out));

    // Random map, random reads and marks (some with a read in the same cycle),
    // a mark landing in the done cycle, random sink backpressure.
    for (int k = 0; k < 512; k++) map_b[k] = 8'($urandom);
    load_map(8'($urandom), 8'($urandom), 512);
    for (int k = 0; k < 40; k++) rd($urandom_range(0, 63), $urandom_range(0, 63));
    for (int k = 0; k < 25; k++)
      mark($urandom_range(0, 63), $urandom_range(0, 63), 1'($urandom_range(0, 1)));
    mark(62, 63, 1'b1);
    mark(63, 63, 1'b0);
    r = $urandom_range(0, 63);
    c = $urandom_range(0, 63);
    row = 6'(r); col = 6'(c); we = 1'b1;
    vis_m[r][c] = 1'b1;
    run_dump(1'b1, beats, cycles);

    // Reload without marks: no beats, finish after one full scan.
    for (int k = 0; k < 512; k++) map_b[k] = 8'($urandom);
    load_map(8'h2A, 8'h15, 512);
    run_dump(1'b1, beats, cycles);
    chk("empty_beats", 32'(beats), 32'd0);
    chk("empty_finish_window", 32'(cycles >= 4090 && cycles <= 4098), 32'd1);

    // Reset in SERVE with out = 1.
    for (int k = 0; k < 512; k++) map_b[k] = 8'($urandom);
    map_b[0][0] = 1'b1;
    load_map(8'h21, 8'h12, 512);
    rd(0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_load_ready", 32'(load_ready), 32'd1);
    chk("arst_start", 32'({starting_row, starting_col}), 32'd0);
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_dump", 32'({dump_valid, dump_row, dump_col}), 32'd0);
    chk("arst_flags", 32'({solver_start, finished}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Partial load of 100 bytes, reset, then a fresh full load.
    for (int k = 0; k < 512; k++) map_b[k] = 8'hFF;
    load_map(8'h11, 8'h22, 100);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 512; k++) map_b[k] = 8'($urandom);
    map_b[0][0] = 1'b0;
    load_map(8'h0A, 8'h0B, 512);
    rd(0, 0);
    for (int k = 0; k < 30; k++) rd($urandom_range(0, 63), $urandom_range(0, 63));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
